// File: rtl/ffn_layer_sequencer.sv
// ffn_layer_sequencer
// Control sequencer for the pipelined feed-forward layer datapath. It accepts one job over a
// valid/ready handshake, pulses dp_load, streams NUM_TILES weight-tile reads, follows each tile
// through the datapath latency to strobe cap_en/cap_tile, then holds out_valid until
// out_ready.
//
// Optional feature: define FFN_SEQ_PERF_EN to add the perf_cycles job-latency counter.
//
// Ports:
//   clock, reset          - rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   - job request handshake (in_ready only in IDLE)
//   wt_base               - first weight tile address, sampled on accept
//   wt_rd / wt_addr       - weight memory read strobe and address (1-cycle read latency)
//   dp_load               - one-cycle pulse to latch the input neurons
//   dp_issue              - weight operands valid at the datapath inputs
//   cap_en / cap_tile     - datapath result valid for tile cap_tile
//   out_valid / out_ready - layer result handshake towards the softmax stage
//   busy                  - sequencer not idle
//   perf_cycles           - (FFN_SEQ_PERF_EN only) cycles from accept to out_valid
module ffn_layer_sequencer #(
    parameter int unsigned NUM_TILES = 4,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned PIPE_LAT  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] wt_base,
    output logic              wt_rd,
    output logic [ADDR_W-1:0] wt_addr,
    output logic              dp_load,
    output logic              dp_issue,
    output logic              cap_en,
    output logic [3:0]        cap_tile,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef FFN_SEQ_PERF_EN
    output logic              busy,
    output logic [15:0]       perf_cycles
`else
    output logic              busy
`endif
);

    localparam logic [3:0] LAST_TILE = 4'(NUM_TILES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StIssue,
        StDrain,
        StOut
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [3:0]        tile_q, tile_d;
    logic              issue_q;
    logic [3:0]        issue_tile_q;
    logic [PIPE_LAT-1:0] lat_vld_q;
    logic [3:0]        lat_tile_q [PIPE_LAT];
    logic              accept;

    assign accept = (state_q == StIdle) && in_valid;

    // State register, base address latch and read-tile counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            base_q  <= '0;
            tile_q  <= '0;
        end else begin
            state_q <= state_d;
            tile_q  <= tile_d;
            if (accept) begin
                base_q <= wt_base;
            end
        end
    end

    // Read data arrives one cycle after wt_rd; the tile index rides along with it.
    // The latency line below runs regardless of state so in-flight tiles keep moving.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issue_q      <= 1'b0;
            issue_tile_q <= '0;
            lat_vld_q    <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                lat_tile_q[i] <= '0;
            end
        end else begin
            issue_q       <= wt_rd;
            issue_tile_q  <= tile_q;
            lat_vld_q[0]  <= issue_q;
            lat_tile_q[0] <= issue_tile_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                lat_vld_q[i]  <= lat_vld_q[i-1];
                lat_tile_q[i] <= lat_tile_q[i-1];
            end
        end
    end

    assign dp_issue = issue_q;
    assign cap_en   = lat_vld_q[PIPE_LAT-1];
    assign cap_tile = lat_tile_q[PIPE_LAT-1];

    // Next-state and state-decoded outputs
    always_comb begin
        state_d   = state_q;
        tile_d    = tile_q;
        in_ready  = 1'b0;
        dp_load   = 1'b0;
        wt_rd     = 1'b0;
        wt_addr   = '0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                dp_load = 1'b1;
                tile_d  = '0;
                state_d = StIssue;
            end
            StIssue: begin
                wt_rd   = 1'b1;
                // Modulo 2^ADDR_W wrap falls out of the truncating add
                wt_addr = base_q + ADDR_W'(tile_q);
                if (tile_q == LAST_TILE) begin
                    tile_d  = '0;
                    state_d = StDrain;
                end else begin
                    tile_d = tile_q + 4'd1;
                end
            end
            StDrain: begin
                if (cap_en && (cap_tile == LAST_TILE)) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

`ifdef FFN_SEQ_PERF_EN
    // The accept cycle counts as the first cycle, so the value seen when out_valid first
    // rises equals the accept-to-out_valid distance. Holds in OUT and IDLE.
    logic [15:0] perf_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_q <= '0;
        end else if (accept) begin
            perf_q <= 16'd1;
        end else if ((state_q != StIdle) && (state_q != StOut) && (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_ffn_layer_sequencer.sv
// Scoreboard bench for ffn_layer_sequencer: a default-parameter instance and a
// NUM_TILES=1 / PIPE_LAT=1 instance. Stimulus pushes timed expectations; monitors pop them.
module tb_ffn_layer_sequencer;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_valid2 = 1'b0;
    logic       out_ready = 1'b1;
    logic       out_ready2 = 1'b1;
    logic [7:0] wt_base = '0;

    logic       in_ready, wt_rd, dp_load, dp_issue, cap_en, out_valid, busy;
    logic [7:0] wt_addr;
    logic [3:0] cap_tile;
    logic       in_ready2, wt_rd2, dp_load2, dp_issue2, cap_en2, out_valid2, busy2;
    logic [7:0] wt_addr2;
    logic [3:0] cap_tile2;
`ifdef FFN_SEQ_PERF_EN
    logic [15:0] perf_cycles, perf_cycles2;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    ev_t load_q[$], addr_q[$], cap_q[$], out_q[$];
    ev_t addr2_q[$], cap2_q[$], out2_q[$];

    ffn_layer_sequencer #(.NUM_TILES(4), .ADDR_W(8), .PIPE_LAT(5)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .wt_base(wt_base), .wt_rd(wt_rd), .wt_addr(wt_addr), .dp_load(dp_load),
        .dp_issue(dp_issue), .cap_en(cap_en), .cap_tile(cap_tile), .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef FFN_SEQ_PERF_EN
        .perf_cycles(perf_cycles),
`endif
        .busy(busy)
    );

    ffn_layer_sequencer #(.NUM_TILES(1), .ADDR_W(8), .PIPE_LAT(1)) dut2 (
        .clock(clock), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .wt_base(wt_base), .wt_rd(wt_rd2), .wt_addr(wt_addr2), .dp_load(dp_load2),
        .dp_issue(dp_issue2), .cap_en(cap_en2), .cap_tile(cap_tile2), .out_valid(out_valid2),
        .out_ready(out_ready2),
`ifdef FFN_SEQ_PERF_EN
        .perf_cycles(perf_cycles2),
`endif
        .busy(busy2)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_ev(input string nm, input ev_t e, input int val_a);
        n_checks++;
        if (cyc != e.cyc || val_a != e.val) begin
            n_fail++;
            $display("FAIL %s: actual cycle %0d value 0x%0h, required cycle %0d value 0x%0h",
                     nm, cyc, val_a, e.cyc, e.val);
        end
    endtask

    task automatic unexpected(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event at cycle %0d with nothing expected", nm, cyc);
    endtask

    // Monitor for the default instance
    logic ov_prev = 1'b0;
    always @(negedge clock) begin
        if (dp_load) begin
            if (load_q.size() == 0) unexpected("dp_load");
            else check_ev("dp_load", load_q.pop_front(), int'(in_ready));
        end
        if (wt_rd) begin
            if (addr_q.size() == 0) unexpected("wt_rd");
            else check_ev("wt_addr", addr_q.pop_front(), int'(wt_addr));
        end
        if (cap_en) begin
            if (cap_q.size() == 0) unexpected("cap_en");
            else check_ev("cap_tile", cap_q.pop_front(), int'(cap_tile));
        end
        if (out_valid && !ov_prev) begin
            if (out_q.size() == 0) unexpected("out_valid");
            else check_ev("out_valid", out_q.pop_front(), int'(busy));
`ifdef FFN_SEQ_PERF_EN
            check("perf_at_out", 32'(perf_cycles), 32'd12);
`endif
        end
        ov_prev = out_valid;
    end

    // Monitor for the NUM_TILES=1 / PIPE_LAT=1 instance
    logic ov2_prev = 1'b0;
    always @(negedge clock) begin
        if (wt_rd2) begin
            if (addr2_q.size() == 0) unexpected("wt_rd2");
            else check_ev("wt_addr2", addr2_q.pop_front(), int'(wt_addr2));
        end
        if (cap_en2) begin
            if (cap2_q.size() == 0) unexpected("cap_en2");
            else check_ev("cap_tile2", cap2_q.pop_front(), int'(cap_tile2));
        end
        if (out_valid2 && !ov2_prev) begin
            if (out2_q.size() == 0) unexpected("out_valid2");
            else check_ev("out_valid2", out2_q.pop_front(), int'(busy2));
`ifdef FFN_SEQ_PERF_EN
            check("perf2_at_out", 32'(perf_cycles2), 32'd5);
`endif
        end
        ov2_prev = out_valid2;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Accept in cycle A on the default instance: N=4, L=5
    task automatic start_job(input logic [7:0] base);
        int a;
        @(posedge clock);
        #1;
        a = cyc;
        in_valid = 1'b1;
        wt_base  = base;
        load_q.push_back('{cyc: a + 1, val: 0});
        for (int k = 0; k < 4; k++) begin
            addr_q.push_back('{cyc: a + 2 + k, val: int'(8'(base + 8'(k)))});
            cap_q.push_back('{cyc: a + 8 + k, val: k});
        end
        out_q.push_back('{cyc: a + 12, val: 1});
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_strobes"}, {27'd0, wt_rd, dp_load, dp_issue, cap_en, out_valid}, 32'd0);
        check({tag, "_addr_tile"}, {20'd0, wt_addr, cap_tile}, 32'd0);
    endtask

    initial begin
        int a;
        // Reset state
        wait_cycles(3);
        check_reset_outputs("reset");
        check("reset_in_ready2", 32'(in_ready2), 32'd1);
`ifdef FFN_SEQ_PERF_EN
        check("reset_perf", 32'(perf_cycles), 32'd0);
`endif
        reset = 1'b0;
        wait_cycles(2);

        // Default job and address wrap
        start_job(8'h10);
        wait_cycles(13);
        check("idle_after_job", 32'(in_ready), 32'd1);
        start_job(8'hFE);
        wait_cycles(13);

        // Backpressure: out_ready low through 10 cycles of OUT, stray in_valid pulses
        out_ready = 1'b0;
        start_job(8'h20);
        wait_cycles(11);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 3 == 0);
            @(negedge clock);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
`ifdef FFN_SEQ_PERF_EN
            check("bp_perf_hold", 32'(perf_cycles), 32'd12);
`endif
            @(posedge clock);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        wait_cycles(2);

        // Reset asserted during ISSUE (cycle A+4); pending expectations are void
        start_job(8'h40);
        wait_cycles(3);
        reset = 1'b1;
        load_q.delete();
        addr_q.delete();
        cap_q.delete();
        out_q.delete();
        #1;
        check_reset_outputs("midreset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        wait_cycles(20);
        start_job(8'h50);
        wait_cycles(13);

        // Edge parameters: single tile, single-cycle latency
        @(posedge clock);
        #1;
        a = cyc;
        in_valid2 = 1'b1;
        wt_base   = 8'h33;
        addr2_q.push_back('{cyc: a + 2, val: 'h33});
        cap2_q.push_back('{cyc: a + 4, val: 0});
        out2_q.push_back('{cyc: a + 5, val: 1});
        @(posedge clock);
        #1;
        in_valid2 = 1'b0;
        wait_cycles(8);
        check("idle2_after_job", 32'(in_ready2), 32'd1);

        // Every expected event must have been seen
        check("load_q_drained", 32'(load_q.size()), 32'd0);
        check("addr_q_drained", 32'(addr_q.size()), 32'd0);
        check("cap_q_drained", 32'(cap_q.size()), 32'd0);
        check("out_q_drained", 32'(out_q.size()), 32'd0);
        check("addr2_q_drained", 32'(addr2_q.size()), 32'd0);
        check("cap2_q_drained", 32'(cap2_q.size()), 32'd0);
        check("out2_q_drained", 32'(out2_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ffn_layer_sequencer.md
# ffn_layer_sequencer

Control sequencer for the fully pipelined feed-forward layer datapath (multiplier array plus adder tree). It accepts one input-vector job over a valid/ready handshake, loads the input neurons into the datapath, and streams `NUM_TILES` weight tiles from weight memory, one per cycle. It tracks the datapath pipeline latency to pulse a per-tile capture strobe, then holds a result-valid handshake until the downstream (softmax) stage accepts.

## Interface
- `NUM_TILES`, default 4: weight tiles per job; legal range 1..16.
- `ADDR_W`, default 8: weight memory address width.
- `PIPE_LAT`, default 5: cycles from `dp_issue` to the matching result at the datapath output; legal range 1..31.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: upstream job request.
- `in_ready` out 1: high only in IDLE.
- `wt_base` in ADDR_W: first tile address; sampled on accept.
- `wt_rd` out 1: weight memory read strobe; the memory has 1-cycle read latency.
- `wt_addr` out ADDR_W: weight memory read address.
- `dp_load` out 1: one-cycle pulse that latches the input neurons into the datapath.
- `dp_issue` out 1: weight operands are valid at the datapath inputs.
- `cap_en` out 1: the datapath result for `cap_tile` is valid this cycle.
- `cap_tile` out 4: tile index for the current `cap_en`.
- `out_valid` out 1: the whole layer result is captured.
- `out_ready` in 1: downstream accepts the result.
- `busy` out 1: state is not IDLE.

## Operation
- States are IDLE, LOAD, ISSUE, DRAIN and OUT.
- **IDLE:** `in_ready`=1. When `in_valid`=1, register `wt_base` and go to LOAD.
- **LOAD:** `dp_load`=1 for one cycle, then go to ISSUE.
- **ISSUE:**
  - `wt_rd`=1 for exactly `NUM_TILES` consecutive cycles, on addresses `wt_base`+k for k=0..NUM_TILES-1.
  - Address arithmetic is modulo 2^ADDR_W, so 0xFF+1 wraps to 0x00.
  - After the last read, go to DRAIN.
- `dp_issue` is `wt_rd` delayed 1 cycle. The tile index travels with it.
- `cap_en` and `cap_tile` are `dp_issue` and its tile index delayed `PIPE_LAT` cycles through a shift register. This path is independent of state.
- **DRAIN:** wait until `cap_en` pulses for tile NUM_TILES-1, then go to OUT on the next cycle.
- **OUT:** hold `out_valid`=1 until `out_ready`=1, then go to IDLE. The result is not dropped while `out_ready`=0. `out_ready` is ignored in all other states.
- The block does not stall mid-job: once accepted, a job runs to OUT regardless of `out_ready`.
- `in_valid` is ignored outside IDLE. There is no job queue.

## Timing
- **Reset values** (held while `reset`=1):
  - State is IDLE.
  - `in_ready`=1, since it is decoded combinationally from IDLE.
  - `busy`=0.
  - `wt_rd`, `dp_load`, `dp_issue`, `cap_en`, `out_valid` = 0.
  - `wt_addr`=0 and `cap_tile`=0.
  - The latency shift register clears entirely.
- **Accept at cycle 0** (`in_valid`&`in_ready`):
  - `dp_load` at cycle 1.
  - `wt_rd` at cycles 2..NUM_TILES+1.
  - `dp_issue` at cycles 3..NUM_TILES+2.
  - `cap_en` at cycles 3+PIPE_LAT..NUM_TILES+2+PIPE_LAT.
  - `out_valid` rises at cycle NUM_TILES+3+PIPE_LAT.
- Defaults give `cap_en` at cycles 8..11 and `out_valid` at cycle 12.
- `out_valid`&`out_ready` in cycle t gives IDLE in t+1. The minimum job-to-job spacing is NUM_TILES+4+PIPE_LAT cycles.
- **Reset mid-job:** outputs reach reset values immediately. No `cap_en` or `out_valid` appears afterwards from the aborted job.

## Configuration
- `FFN_SEQ_PERF_EN` defined:
  - Adds output `perf_cycles` [15:0]. It clears on accept and increments every cycle until `out_valid` first rises.
  - It then holds until the next accept, saturating at 0xFFFF. Its reset value is 0.
- `FFN_SEQ_PERF_EN` undefined: the port and counter are absent, and behaviour is otherwise identical.

## Test plan
- **Default job:** reset, then `wt_base`=0x10 with `in_valid` pulsed at cycle 0.
  - `wt_addr` = 0x10..0x13 at cycles 2..5.
  - `cap_tile` = 0..3 with `cap_en` at cycles 8..11.
  - `out_valid` at cycle 12.
- **Address wrap:** `wt_base`=0xFE with defaults -> addresses 0xFE, 0xFF, 0x00, 0x01.
- **Backpressure:** `out_ready`=0 for 10 cycles after `out_valid` rises.
  - `out_valid` stays 1 and `in_ready` stays 0.
  - `in_valid` pulses during this window are ignored.
  - Once `out_ready`=1, IDLE follows on the next cycle.
- **Reset during ISSUE:** assert `reset` at cycle 4.
  - All outputs reach reset values at once.
  - No `cap_en` occurs in the following 20 cycles.
  - A new job then completes normally.
- **Edge parameters:** NUM_TILES=1, PIPE_LAT=1 -> single `wt_rd` at cycle 2, `cap_en` at cycle 4 with `cap_tile`=0, `out_valid` at cycle 5.
- **Perf counter** (with `FFN_SEQ_PERF_EN` defined, defaults): `perf_cycles`=12 when `out_valid` first rises, and it holds 12 while `out_ready`=0.
